fifo_ctrl: RTL and testbench

Control and pointer logic for the interconnect FIFO. It accepts push/pop requests from the producer and consumer sides and issues qualified push_mem/pop_mem strobes and wr_ptr/rd_ptr to the FIFO storage module. It tracks occupancy and produces full/empty, threshold flags, error flags and a read-data-valid strobe aligned with the storage read data.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_ptr.sv | 23 ++
 rtl/fifo_ctrl.sv | 101 ++++++++++
 tb/tb_fifo_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the interconnect FIFO control slice: default depth,
// width derivation helpers and the reset values of pointers and occupancy.
package fifo_pkg;

  localparam int FIFO_MEM_SIZE_DEF = 4;

  localparam int PTR_RST_VAL = 0;
  localparam int CNT_RST_VAL = 0;

  // Pointer width that addresses every entry of a power-of-two FIFO.
  function automatic int fifo_ptr_w(input int mem_size);
    return $clog2(mem_size);
  endfunction

  // Occupancy needs one extra bit so that "completely full" is representable.
  function automatic int fifo_cnt_w(input int mem_size);
    return $clog2(mem_size) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping storage address counter. Wrap-around relies on the natural overflow
// of PTR_L bits, so the FIFO depth must be a power of two.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int PTR_L = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [PTR_L-1:0] ptr
);

  // Advance by one on each qualified strobe; reset returns to the first entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PTR_L'(PTR_RST_VAL);
    end else if (en) begin
      ptr <= ptr + PTR_L'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Control and pointer logic for the interconnect FIFO. Qualifies producer and
// consumer requests into storage strobes, tracks occupancy, and reports the
// status/threshold/error flags plus a read-data-valid strobe aligned with the
// one-cycle storage read latency.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int MEM_SIZE = FIFO_MEM_SIZE_DEF,
  parameter int PTR_L    = fifo_ptr_w(MEM_SIZE),
  parameter int CNT_L    = fifo_cnt_w(MEM_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [CNT_L-1:0] af_th,
  input  logic [CNT_L-1:0] ae_th,
  output logic             push_mem,
  output logic             pop_mem,
  output logic [PTR_L-1:0] wr_ptr,
  output logic [PTR_L-1:0] rd_ptr,
  output logic [CNT_L-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             data_valid,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CNT_L-1:0] CNT_FULL = CNT_L'(MEM_SIZE);
  localparam logic [CNT_L-1:0] CNT_ZERO = CNT_L'(0);

  // Status flags decode straight from the registered count so they are always
  // coherent with it; thresholds are compared live.
  always_comb begin
    full         = (count == CNT_FULL);
    empty        = (count == CNT_ZERO);
    almost_full  = (count >= af_th);
    almost_empty = (count <= ae_th);
  end

  // Request qualification. A pop is judged first so that a push into a full
  // FIFO can ride on a same-cycle accepted pop; reset blocks both strobes.
  always_comb begin
    pop_mem  = pop & ~empty & ~reset;
    push_mem = push & (~full | pop_mem) & ~reset;
  end

  fifo_ptr #(
    .PTR_L (PTR_L)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (push_mem),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(
    .PTR_L (PTR_L)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en    (pop_mem),
    .ptr   (rd_ptr)
  );

  // Occupancy: net change of the two strobes; the qualification above keeps
  // it inside 0..MEM_SIZE.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= CNT_L'(CNT_RST_VAL);
    end else if (push_mem && !pop_mem) begin
      count <= count + CNT_L'(1);
    end else if (pop_mem && !push_mem) begin
      count <= count - CNT_L'(1);
    end
  end

  // ---- stage p0 -> p1: read strobe delayed to line up with storage data ----
  always_ff @(posedge clk) begin
    if (reset) begin
      data_valid <= 1'b0;
    end else begin
      data_valid <= pop_mem;
    end
  end

  // Sticky error flags: any rejected request outside reset, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow  | (push & ~push_mem);
      underflow <= underflow | (pop  & ~pop_mem);
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl (MEM_SIZE=4). Inputs change 1 time unit after
// the rising edge; strobes are observed before the next edge and registered
// results 1 time unit after it.
module tb_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic       pop;
  logic [2:0] af_th;
  logic [2:0] ae_th;
  logic       push_mem;
  logic       pop_mem;
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       data_valid;
  logic       overflow;
  logic       underflow;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(
    .MEM_SIZE (4),
    .PTR_L    (2),
    .CNT_L    (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .af_th        (af_th),
    .ae_th        (ae_th),
    .push_mem     (push_mem),
    .pop_mem      (pop_mem),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_valid   (data_valid),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; push = 1'b0; pop = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; push = 1'b1; pop = 1'b1; af_th = 3'd3; ae_th = 3'd1;
    step();
    step();
    #1;
    tests_run++; if (push_mem !== 1'b0) begin failures++; $display("FAIL reset_push_mem got=%b exp=0", push_mem); end
    tests_run++; if (pop_mem !== 1'b0) begin failures++; $display("FAIL reset_pop_mem got=%b exp=0", pop_mem); end
    tests_run++; if (wr_ptr !== 2'd0) begin failures++; $display("FAIL reset_wr_ptr got=%0d exp=0", wr_ptr); end
    tests_run++; if (rd_ptr !== 2'd0) begin failures++; $display("FAIL reset_rd_ptr got=%0d exp=0", rd_ptr); end
    tests_run++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    tests_run++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    tests_run++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    tests_run++; if (almost_empty !== 1'b1) begin failures++; $display("FAIL reset_almost_empty got=%b exp=1", almost_empty); end
    tests_run++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_almost_full got=%b exp=0", almost_full); end
    tests_run++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    tests_run++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%b exp=0", underflow); end
    tests_run++; if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    reset = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_fill();
    logic       e_pm   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] e_wr   [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    logic [2:0] e_cnt  [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       e_af   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       e_full [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       e_ovf  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    af_th = 3'd3; ae_th = 3'd1;
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; pop = 1'b0;
      #1;
      tests_run++; if (push_mem !== e_pm[i]) begin failures++; $display("FAIL fill_push_mem[%0d] got=%b exp=%b", i, push_mem, e_pm[i]); end
      step();
      tests_run++; if (wr_ptr !== e_wr[i]) begin failures++; $display("FAIL fill_wr_ptr[%0d] got=%0d exp=%0d", i, wr_ptr, e_wr[i]); end
      tests_run++; if (count !== e_cnt[i]) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, e_cnt[i]); end
      tests_run++; if (almost_full !== e_af[i]) begin failures++; $display("FAIL fill_almost_full[%0d] got=%b exp=%b", i, almost_full, e_af[i]); end
      tests_run++; if (full !== e_full[i]) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, e_full[i]); end
      tests_run++; if (overflow !== e_ovf[i]) begin failures++; $display("FAIL fill_overflow[%0d] got=%b exp=%b", i, overflow, e_ovf[i]); end
    end
    push = 1'b0;
  endtask

  task automatic test_drain();
    logic       e_pm  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] e_rd  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    logic [2:0] e_cnt [5] = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    logic       e_dv  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       e_emp [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       e_ae  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       e_unf [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      push = 1'b0; pop = 1'b1;
      #1;
      tests_run++; if (pop_mem !== e_pm[i]) begin failures++; $display("FAIL drain_pop_mem[%0d] got=%b exp=%b", i, pop_mem, e_pm[i]); end
      step();
      tests_run++; if (rd_ptr !== e_rd[i]) begin failures++; $display("FAIL drain_rd_ptr[%0d] got=%0d exp=%0d", i, rd_ptr, e_rd[i]); end
      tests_run++; if (count !== e_cnt[i]) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, e_cnt[i]); end
      tests_run++; if (data_valid !== e_dv[i]) begin failures++; $display("FAIL drain_data_valid[%0d] got=%b exp=%b", i, data_valid, e_dv[i]); end
      tests_run++; if (empty !== e_emp[i]) begin failures++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, empty, e_emp[i]); end
      tests_run++; if (almost_empty !== e_ae[i]) begin failures++; $display("FAIL drain_almost_empty[%0d] got=%b exp=%b", i, almost_empty, e_ae[i]); end
      tests_run++; if (underflow !== e_unf[i]) begin failures++; $display("FAIL drain_underflow[%0d] got=%b exp=%b", i, underflow, e_unf[i]); end
    end
    pop = 1'b0;
    tests_run++; if (overflow !== 1'b1) begin failures++; $display("FAIL drain_overflow_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [1:0] e_ptr [3] = '{2'd1, 2'd2, 2'd3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; pop = 1'b0;
      step();
    end
    tests_run++; if (count !== 3'd4) begin failures++; $display("FAIL fpp_prefill_count got=%0d exp=4", count); end
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; pop = 1'b1;
      #1;
      tests_run++; if (push_mem !== 1'b1) begin failures++; $display("FAIL fpp_push_mem[%0d] got=%b exp=1", i, push_mem); end
      tests_run++; if (pop_mem !== 1'b1) begin failures++; $display("FAIL fpp_pop_mem[%0d] got=%b exp=1", i, pop_mem); end
      step();
      tests_run++; if (count !== 3'd4) begin failures++; $display("FAIL fpp_count[%0d] got=%0d exp=4", i, count); end
      tests_run++; if (wr_ptr !== e_ptr[i]) begin failures++; $display("FAIL fpp_wr_ptr[%0d] got=%0d exp=%0d", i, wr_ptr, e_ptr[i]); end
      tests_run++; if (rd_ptr !== e_ptr[i]) begin failures++; $display("FAIL fpp_rd_ptr[%0d] got=%0d exp=%0d", i, rd_ptr, e_ptr[i]); end
      tests_run++; if (overflow !== 1'b0) begin failures++; $display("FAIL fpp_overflow[%0d] got=%b exp=0", i, overflow); end
    end
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_empty_push_pop();
    do_reset();
    push = 1'b1; pop = 1'b1;
    #1;
    tests_run++; if (push_mem !== 1'b1) begin failures++; $display("FAIL epp_push_mem got=%b exp=1", push_mem); end
    tests_run++; if (pop_mem !== 1'b0) begin failures++; $display("FAIL epp_pop_mem got=%b exp=0", pop_mem); end
    step();
    push = 1'b0; pop = 1'b0;
    tests_run++; if (count !== 3'd1) begin failures++; $display("FAIL epp_count got=%0d exp=1", count); end
    tests_run++; if (wr_ptr !== 2'd1) begin failures++; $display("FAIL epp_wr_ptr got=%0d exp=1", wr_ptr); end
    tests_run++; if (rd_ptr !== 2'd0) begin failures++; $display("FAIL epp_rd_ptr got=%0d exp=0", rd_ptr); end
    tests_run++; if (underflow !== 1'b1) begin failures++; $display("FAIL epp_underflow got=%b exp=1", underflow); end
    tests_run++; if (overflow !== 1'b0) begin failures++; $display("FAIL epp_overflow got=%b exp=0", overflow); end
    tests_run++; if (data_valid !== 1'b0) begin failures++; $display("FAIL epp_data_valid got=%b exp=0", data_valid); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; pop = 1'b0;
      step();
    end
    for (int i = 0; i < 2; i++) begin
      push = 1'b0; pop = 1'b1;
      step();
    end
    tests_run++; if (count !== 3'd2) begin failures++; $display("FAIL rmo_pre_count got=%0d exp=2", count); end
    tests_run++; if (overflow !== 1'b1) begin failures++; $display("FAIL rmo_pre_overflow got=%b exp=1", overflow); end
    tests_run++; if (data_valid !== 1'b1) begin failures++; $display("FAIL rmo_pre_data_valid got=%b exp=1", data_valid); end
    reset = 1'b1; pop = 1'b1;
    #1;
    tests_run++; if (pop_mem !== 1'b0) begin failures++; $display("FAIL rmo_pop_mem got=%b exp=0", pop_mem); end
    step();
    reset = 1'b0; pop = 1'b0;
    tests_run++; if (count !== 3'd0) begin failures++; $display("FAIL rmo_count got=%0d exp=0", count); end
    tests_run++; if (wr_ptr !== 2'd0) begin failures++; $display("FAIL rmo_wr_ptr got=%0d exp=0", wr_ptr); end
    tests_run++; if (rd_ptr !== 2'd0) begin failures++; $display("FAIL rmo_rd_ptr got=%0d exp=0", rd_ptr); end
    tests_run++; if (overflow !== 1'b0) begin failures++; $display("FAIL rmo_overflow got=%b exp=0", overflow); end
    tests_run++; if (data_valid !== 1'b0) begin failures++; $display("FAIL rmo_data_valid got=%b exp=0", data_valid); end
    tests_run++; if (empty !== 1'b1) begin failures++; $display("FAIL rmo_empty got=%b exp=1", empty); end
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; af_th = 3'd3; ae_th = 3'd1;
    test_reset();
    test_fill();
    test_drain();
    test_full_push_pop();
    test_empty_push_pop();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
